// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path.
// Holds the FSM state enum, opcode and alu_op encodings, the strobe bundle
// driven by the control unit, and small opcode decode helpers.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned OPC_W      = 4;
  localparam int unsigned ALU_OP_W   = 3;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    RESET   = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEMWAIT = 3'd4,
    HALT    = 3'd5,
    FAULT   = 3'd6
  } state_e;

  // Opcodes live in instr[7:4]; unlisted values behave as NOP.
  localparam logic [OPC_W-1:0] OPC_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OPC_LDI = 4'h1;
  localparam logic [OPC_W-1:0] OPC_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OPC_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OPC_AND = 4'h4;
  localparam logic [OPC_W-1:0] OPC_OR  = 4'h5;
  localparam logic [OPC_W-1:0] OPC_XOR = 4'h6;
  localparam logic [OPC_W-1:0] OPC_LD  = 4'h7;
  localparam logic [OPC_W-1:0] OPC_ST  = 4'h8;
  localparam logic [OPC_W-1:0] OPC_JMP = 4'h9;
  localparam logic [OPC_W-1:0] OPC_JZ  = 4'hA;
  localparam logic [OPC_W-1:0] OPC_JC  = 4'hB;
  localparam logic [OPC_W-1:0] OPC_HLT = 4'hF;

  localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_MEM  = 3'b110;

  // Strobe bundle produced each cycle by the control FSM.
  typedef struct packed {
    logic                set_pc;
    logic                pc_inc;
    logic                pc_load;
    logic                ir_load;
    logic                mem_rd;
    logic                mem_wr;
    logic [ALU_OP_W-1:0] alu_op;
    logic                acc_we;
    logic                halted;
    logic                fault;
  } ctrl_out_t;

  // True for the register-to-accumulator ALU opcodes (LDI..XOR).
  function automatic logic is_alu_opc(input logic [OPC_W-1:0] opc);
    return (opc >= OPC_LDI) && (opc <= OPC_XOR);
  endfunction

  // ALU operation select for the ALU opcodes; PASS for anything else.
  function automatic logic [ALU_OP_W-1:0] alu_op_of(input logic [OPC_W-1:0] opc);
    logic [ALU_OP_W-1:0] op;
    op = ALU_PASS;
    case (opc)
      OPC_LDI: op = ALU_PASS;
      OPC_ADD: op = ALU_ADD;
      OPC_SUB: op = ALU_SUB;
      OPC_AND: op = ALU_AND;
      OPC_OR:  op = ALU_OR;
      OPC_XOR: op = ALU_XOR;
      default: op = ALU_PASS;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_timeout.sv
// Memory-request wait counter for the control unit.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset (clears the count)
//   clr     - clear the count this edge (mem_ready seen or FSM state change)
//   en      - a request strobe is up and mem_ready is low this cycle
//   expired - this cycle's unanswered request brings the count to MEM_TIMEOUT
module ctrl_timeout
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Looks one increment ahead so the FSM leaves on the MEM_TIMEOUT-th
  // unanswered cycle rather than one cycle later. Independent of clr so the
  // FSM can derive clr from its next state without a combinational loop.
  assign expired = en && ((32'(cnt_q) + 32'd1) >= MEM_TIMEOUT);

  // Clear wins over count; the count saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Control FSM for a small accumulator CPU: fetch / decode / execute with a
// memory handshake, a request timeout that faults, and sticky HALT/FAULT.
// Config macro: CTRL_BRANCH_EN enables JZ/JC; without it opcodes A/B are NOP
// and zero/carry are ignored.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   instr[7:0]         - instruction from memory ([7:4] opcode, [3:0] operand)
//   zero, carry        - ALU flags, used in EXECUTE for conditional jumps
//   mem_ready          - memory acknowledge (only looked at in FETCH/MEMWAIT)
//   set_pc             - force PC to zero
//   pc_inc, pc_load    - PC increment / load from operand
//   ir_load            - capture instr into the instruction register
//   mem_rd, mem_wr     - memory request strobes
//   alu_op[2:0]        - ALU operation select
//   acc_we             - accumulator write enable
//   halted, fault      - sticky status, cleared only by rst
// Strobes are decoded from the state register and, for handshake
// completion, from mem_ready in the same cycle, so a zero-wait access costs
// a single cycle.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       zero,
  input  logic       carry,
  input  logic       mem_ready,
  output logic       set_pc,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ir_load,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [2:0] alu_op,
  output logic       acc_we,
  output logic       halted,
  output logic       fault
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  ctrl_out_t        out_c;
  logic             branch_taken;
  logic             tmo_clr, tmo_en, tmo_expired;

  // Operand bits go straight to the datapath; only the opcode is kept here.
  logic [3:0] unused_operand;
  assign unused_operand = instr[3:0];

`ifdef CTRL_BRANCH_EN
  // JMP always loads; JZ/JC load only when their flag is set.
  always_comb begin
    branch_taken = 1'b0;
    case (opc_q)
      OPC_JMP: branch_taken = 1'b1;
      OPC_JZ:  branch_taken = zero;
      OPC_JC:  branch_taken = carry;
      default: branch_taken = 1'b0;
    endcase
  end
`else
  assign branch_taken = (opc_q == OPC_JMP);

  logic unused_flags;
  assign unused_flags = zero ^ carry;
`endif

  // Counts only in request states while the acknowledge is missing.
  assign tmo_en  = ((state_q == FETCH) || (state_q == MEMWAIT)) && !mem_ready;
  assign tmo_clr = mem_ready || (state_d != state_q);

  ctrl_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    out_c   = '0;

    unique case (state_q)
      RESET: begin
        out_c.set_pc = 1'b1;
        state_d      = FETCH;
      end

      FETCH: begin
        out_c.mem_rd = 1'b1;
        if (mem_ready) begin
          out_c.ir_load = 1'b1;
          out_c.pc_inc  = 1'b1;
          opc_d         = instr[7:4];
          state_d       = DECODE;
        end else if (tmo_expired) begin
          state_d = FAULT;
        end
      end

      DECODE: begin
        state_d = EXECUTE;
      end

      EXECUTE: begin
        state_d = FETCH;
        if (is_alu_opc(opc_q)) begin
          out_c.acc_we = 1'b1;
          out_c.alu_op = alu_op_of(opc_q);
        end else if ((opc_q == OPC_LD) || (opc_q == OPC_ST)) begin
          state_d = MEMWAIT;
        end else if (opc_q == OPC_HLT) begin
          state_d = HALT;
        end else begin
          // Jumps, disabled branches and NOP-class opcodes land here.
          out_c.pc_load = branch_taken;
        end
      end

      MEMWAIT: begin
        if (opc_q == OPC_LD) begin
          out_c.mem_rd = 1'b1;
        end else begin
          out_c.mem_wr = 1'b1;
        end
        if (mem_ready) begin
          if (opc_q == OPC_LD) begin
            out_c.acc_we = 1'b1;
            out_c.alu_op = ALU_MEM;
          end
          state_d = FETCH;
        end else if (tmo_expired) begin
          state_d = FAULT;
        end
      end

      HALT: begin
        out_c.halted = 1'b1;
      end

      FAULT: begin
        out_c.fault = 1'b1;
      end

      default: begin
        state_d = RESET;
      end
    endcase

    // Reset silences every strobe immediately, even mid-handshake.
    if (rst) begin
      out_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
      opc_q   <= OPC_NOP;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  assign set_pc  = out_c.set_pc;
  assign pc_inc  = out_c.pc_inc;
  assign pc_load = out_c.pc_load;
  assign ir_load = out_c.ir_load;
  assign mem_rd  = out_c.mem_rd;
  assign mem_wr  = out_c.mem_wr;
  assign alu_op  = out_c.alu_op;
  assign acc_we  = out_c.acc_we;
  assign halted  = out_c.halted;
  assign fault   = out_c.fault;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a directed vector table, a few multi-cycle
// sequences, then random instructions checked against a per-instruction
// expected-trace model.
module tb_control_unit;

  localparam int unsigned TMO = 8;
`ifdef CTRL_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  typedef struct packed {
    logic       set_pc;
    logic       pc_inc;
    logic       pc_load;
    logic       ir_load;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] alu_op;
    logic       acc_we;
    logic       halted;
    logic       fault;
  } out_t;

  typedef struct {
    logic       r;
    logic [7:0] ins;
    logic       z;
    logic       c;
    logic       rdy;
    out_t       exp;
  } vec_t;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] instr     = 8'h00;
  logic       zero      = 1'b0;
  logic       carry     = 1'b0;
  logic       mem_ready = 1'b0;
  logic       set_pc, pc_inc, pc_load, ir_load, mem_rd, mem_wr;
  logic [2:0] alu_op;
  logic       acc_we, halted, fault;
  out_t       act;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned cyc    = 0;
  vec_t        tbl[$];

  control_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .zero     (zero),
    .carry    (carry),
    .mem_ready(mem_ready),
    .set_pc   (set_pc),
    .pc_inc   (pc_inc),
    .pc_load  (pc_load),
    .ir_load  (ir_load),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .alu_op   (alu_op),
    .acc_we   (acc_we),
    .halted   (halted),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  assign act = {set_pc, pc_inc, pc_load, ir_load, mem_rd, mem_wr, alu_op, acc_we, halted, fault};

  // Expected-output builders.
  function automatic out_t o_setpc();
    out_t o = '0; o.set_pc = 1'b1; return o;
  endfunction
  function automatic out_t o_rd();
    out_t o = '0; o.mem_rd = 1'b1; return o;
  endfunction
  function automatic out_t o_wr();
    out_t o = '0; o.mem_wr = 1'b1; return o;
  endfunction
  function automatic out_t o_fdone();
    out_t o = '0; o.mem_rd = 1'b1; o.ir_load = 1'b1; o.pc_inc = 1'b1; return o;
  endfunction
  function automatic out_t o_ldone();
    out_t o = '0; o.mem_rd = 1'b1; o.acc_we = 1'b1; o.alu_op = 3'b110; return o;
  endfunction
  function automatic out_t o_alu(input logic [2:0] a);
    out_t o = '0; o.acc_we = 1'b1; o.alu_op = a; return o;
  endfunction
  function automatic out_t o_br(input logic t);
    out_t o = '0; o.pc_load = t; return o;
  endfunction
  function automatic out_t o_halt();
    out_t o = '0; o.halted = 1'b1; return o;
  endfunction
  function automatic out_t o_fault();
    out_t o = '0; o.fault = 1'b1; return o;
  endfunction

  // EXECUTE-cycle outputs straight from the opcode table.
  function automatic out_t exp_exec(input int unsigned opc, input logic z, input logic c);
    out_t o = '0;
    if (opc >= 1 && opc <= 6) begin
      o.acc_we = 1'b1;
      o.alu_op = 3'(opc - 1);
    end else if (opc == 9) begin
      o.pc_load = 1'b1;
    end else if (opc == 10) begin
      o.pc_load = BR_EN & z;
    end else if (opc == 11) begin
      o.pc_load = BR_EN & c;
    end
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction
  function automatic logic [7:0] rbyte();
    return 8'($urandom);
  endfunction

  // One cycle: drive inputs after the falling edge, compare before the rising edge.
  task automatic apply(input logic r, input logic [7:0] ins, input logic z, input logic c,
                       input logic rdy, input out_t exp, input string tag);
    @(negedge clk);
    rst = r; instr = ins; zero = z; carry = c; mem_ready = rdy;
    #1;
    cyc++;
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %b, expected %b", tag, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    apply(1'b1, rbyte(), rb(), rb(), rb(), '0, "reset_hold");
    apply(1'b1, rbyte(), rb(), rb(), rb(), '0, "reset_hold");
    apply(1'b0, rbyte(), rb(), rb(), rb(), o_setpc(), "set_pc");
  endtask

  // A request phase: `waits` unanswered cycles, then either the ready cycle
  // or, once TMO unanswered cycles have gone by, a sticky fault.
  task automatic req_phase(input bit is_fetch, input bit is_ld, input logic [7:0] ins,
                           input int unsigned waits, output bit faulted);
    out_t req;
    req = (is_fetch || is_ld) ? o_rd() : o_wr();
    faulted = 1'b0;
    for (int unsigned i = 0; i < waits && i < TMO; i++)
      apply(1'b0, rbyte(), rb(), rb(), 1'b0, req, "req_wait");
    if (waits >= TMO) begin
      faulted = 1'b1;
      for (int i = 0; i < 3; i++)
        apply(1'b0, rbyte(), rb(), rb(), rb(), o_fault(), "fault_hold");
    end else if (is_fetch) begin
      apply(1'b0, ins, rb(), rb(), 1'b1, o_fdone(), "fetch_done");
    end else begin
      apply(1'b0, rbyte(), rb(), rb(), 1'b1, is_ld ? o_ldone() : o_wr(), "mem_done");
    end
  endtask

  // Whole instruction; st = 0 normal, 1 faulted, 2 halted.
  task automatic run_instr(input logic [7:0] ins, input int unsigned wf, input int unsigned wm,
                           input logic z, input logic c, output int st);
    bit          flt;
    int unsigned opc;
    opc = 32'(ins[7:4]);
    st  = 0;
    req_phase(1'b1, 1'b0, ins, wf, flt);
    if (flt) begin
      st = 1;
      return;
    end
    apply(1'b0, rbyte(), rb(), rb(), rb(), '0, "decode");
    apply(1'b0, rbyte(), z, c, rb(), exp_exec(opc, z, c), "execute");
    if (opc == 7 || opc == 8) begin
      req_phase(1'b0, opc == 7, ins, wm, flt);
      if (flt) st = 1;
    end else if (opc == 15) begin
      for (int i = 0; i < 3; i++)
        apply(1'b0, rbyte(), rb(), rb(), rb(), o_halt(), "halt_hold");
      st = 2;
    end
  endtask

  initial begin
    int st;
    bit flt;

    // Directed table: reset, ADD, ST with waits, branches, HLT, reset out of HALT.
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, out_t'('0)});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, out_t'('0)});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, o_setpc()});
    tbl.push_back('{1'b0, 8'h25, 1'b0, 1'b0, 1'b1, o_fdone()});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, out_t'('0)});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, o_alu(3'b001)});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o_rd()});
    tbl.push_back('{1'b0, 8'h80, 1'b0, 1'b0, 1'b1, o_fdone()});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, out_t'('0)});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, out_t'('0)});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o_wr()});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o_wr()});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o_wr()});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, o_wr()});
    tbl.push_back('{1'b0, 8'hA3, 1'b1, 1'b0, 1'b1, o_fdone()});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, out_t'('0)});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, o_br(BR_EN)});
    tbl.push_back('{1'b0, 8'hA3, 1'b0, 1'b1, 1'b1, o_fdone()});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, out_t'('0)});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, out_t'('0)});
    tbl.push_back('{1'b0, 8'hB3, 1'b0, 1'b0, 1'b1, o_fdone()});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, out_t'('0)});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, o_br(BR_EN)});
    tbl.push_back('{1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, o_fdone()});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, out_t'('0)});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, out_t'('0)});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, o_halt()});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o_halt()});
    tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, out_t'('0)});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, o_setpc()});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o_rd()});

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].r, tbl[i].ins, tbl[i].z, tbl[i].c, tbl[i].rdy, tbl[i].exp,
            $sformatf("vec%0d", i));

    // Fetch never acknowledged: exactly TMO request cycles, then fault until rst.
    do_reset();
    req_phase(1'b1, 1'b0, 8'h00, TMO, flt);
    apply(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, '0, "fault_clear");
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o_setpc(), "fault_set_pc");

    // Reset mid-LD handshake aborts at once and leaves the wait count cleared.
    req_phase(1'b1, 1'b0, 8'h70, 0, flt);
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, '0, "ld_decode");
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, '0, "ld_execute");
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o_rd(), "ld_wait");
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, o_rd(), "ld_wait");
    apply(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, '0, "abort_rst");
    apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, o_setpc(), "abort_set_pc");
    run_instr(8'h15, TMO - 1, 0, 1'b0, 1'b0, st);

    // Longest legal waits in both phases of an LD, then LD timing out in MEMWAIT.
    run_instr(8'h73, TMO - 1, TMO - 1, 1'b0, 1'b0, st);
    run_instr(8'h73, 0, TMO, 1'b0, 1'b0, st);
    do_reset();

    // Random instruction stream.
    for (int n = 0; n < 250; n++) begin
      logic [7:0]  ins;
      int unsigned wf, wm;
      ins = rbyte();
      wf  = ($urandom_range(0, 11) == 0) ? TMO : $urandom_range(0, TMO - 1);
      wm  = ($urandom_range(0, 11) == 0) ? TMO : $urandom_range(0, TMO - 1);
      run_instr(ins, wf, wm, rb(), rb(), st);
      if (st != 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
